// File: rtl/branch_redirect_pc.sv
// branch_redirect_pc: fetch PC register with BEQ resolution in ID.
// A taken branch redirects fetch to id_pc_i + imm_shifted_i and flushes IF/ID.
// A taken branch seen during a cache stall is parked in PEND until the stall
// releases, then applied.
// Optional macro BRANCH_STATS_EN adds branch/taken event counters.
module branch_redirect_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        pc_write_i,
  input  logic        mem_stall_i,
  input  logic        branch_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [31:0] id_pc_i,
  input  logic [31:0] imm_shifted_i,
  output logic [31:0] pc_o,
  output logic        flush_o,
`ifdef BRANCH_STATS_EN
  output logic [31:0] branch_cnt_o,
  output logic [31:0] taken_cnt_o,
`endif
  output logic        redirect_pending_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pend_target;
  logic        taken;
  logic [31:0] target;
  logic        pend_exit;

  // Branch decision and target; carry out of the add is dropped.
  always_comb begin
    taken     = branch_i & pc_write_i & (rs1_data_i == rs2_data_i);
    target    = id_pc_i + imm_shifted_i;
    pend_exit = (state == PEND) & ~mem_stall_i;
  end

  // IF/ID flush: taken redirect in an unstalled RUN cycle, or PEND release.
  always_comb begin
    flush_o = 1'b0;
    if (!rst_i && !mem_stall_i) begin
      case (state)
        RUN:     flush_o = taken;
        PEND:    flush_o = 1'b1;
        default: flush_o = 1'b0;
      endcase
    end
  end

  // State, PC and pending-redirect registers; stall outranks branch outranks increment.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state              <= IDLE;
      pc_o               <= RESET_PC;
      pend_target        <= '0;
      redirect_pending_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) state <= RUN;
        end
        RUN: begin
          if (mem_stall_i) begin
            if (taken) begin
              pend_target        <= target;
              state              <= PEND;
              redirect_pending_o <= 1'b1;
            end
          end else if (taken) begin
            pc_o <= target;
          end else if (pc_write_i) begin
            pc_o <= pc_o + 32'd4;
          end
        end
        PEND: begin
          if (!mem_stall_i) begin
            pc_o               <= pend_target;
            state              <= RUN;
            redirect_pending_o <= 1'b0;
          end
        end
        default: begin
          state              <= IDLE;
          redirect_pending_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  // Event counters; a stalled branch is counted once, when PEND releases.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      branch_cnt_o <= '0;
      taken_cnt_o  <= '0;
    end else begin
      if (((state == RUN) & branch_i & pc_write_i & ~mem_stall_i) | pend_exit)
        branch_cnt_o <= branch_cnt_o + 32'd1;
      if (((state == RUN) & taken & ~mem_stall_i) | pend_exit)
        taken_cnt_o <= taken_cnt_o + 32'd1;
    end
  end
`endif

endmodule
